// File: rtl/pc_fetch_gen.sv
// Fetch-stage PC generator: holds requests until accepted, arbitrates redirects,
// and tags each request with a wrapping epoch.
module pc_fetch_gen #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VEC = '0,
  parameter bit               C_EXT   = 1'b0,
  parameter int unsigned      EPOCH_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [WIDTH-1:0]   req_pc,
  output logic [EPOCH_W-1:0] req_epoch,
  output logic [WIDTH-1:0]   pc_plus4,
  input  logic               halt,
  input  logic               trap_valid,
  input  logic [WIDTH-1:0]   trap_vec,
  input  logic               br_valid,
  input  logic [WIDTH-1:0]   br_target,
  input  logic               pred_valid,
  input  logic [WIDTH-1:0]   pred_target,
  output logic               misalign_err
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d;
  logic                 valid_q;
  logic                 mis_q, mis_d;
  logic                 redir;
  logic                 accept;
  logic [WIDTH-1:0]     raw_tgt;
  logic [WIDTH-1:0]     tgt;

  assign redir  = trap_valid | br_valid | pred_valid;
  assign accept = valid_q & req_ready;

  assign req_valid    = valid_q;
  assign req_pc       = pc_q;
  assign req_epoch    = epoch_q;
  assign pc_plus4     = pc_q + FOUR;
  assign misalign_err = mis_q;

  // Trap always wins and is forced word aligned; bit 0 is dropped (JALR).
  always_comb begin
    raw_tgt = pred_target;
    if (trap_valid)    raw_tgt = trap_vec;
    else if (br_valid) raw_tgt = br_target;

    tgt   = {raw_tgt[WIDTH-1:2], 2'b00};
    mis_d = 1'b0;
    if (!trap_valid) begin
      if (C_EXT) tgt = {raw_tgt[WIDTH-1:1], 1'b0};
      else       mis_d = redir & raw_tgt[1];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redir) begin
      pc_d    = tgt;
      epoch_d = epoch_q + 1'b1;
    end else if (accept) begin
      pc_d = pc_plus4;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = halt ? S_HALT : S_RUN;
      S_RUN:  if (!redir && accept && halt) state_d = S_HALT;
      S_HALT: if (!halt) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RST_VEC;
      epoch_q <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      valid_q <= (state_d == S_RUN);
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Bench for pc_fetch_gen: directed stimulus feeds a cycle-tagged scoreboard
// that a negedge monitor drains and compares.
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_ready, halt;
  logic        trap_valid, br_valid, pred_valid;
  logic [31:0] trap_vec, br_target, pred_target;

  logic        a_valid, a_mis, b_valid, b_mis;
  logic [31:0] a_pc, a_p4, b_pc, b_p4;
  logic [1:0]  a_ep, b_ep;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          done = 1'b0;

  typedef struct {
    int unsigned cyc;
    bit          sel;
    logic        v;
    logic [31:0] pc;
    logic [1:0]  ep;
    logic        m;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pc_fetch_gen #(.WIDTH(32), .RST_VEC(32'h0), .C_EXT(1'b0), .EPOCH_W(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(req_ready),
    .req_pc(a_pc), .req_epoch(a_ep), .pc_plus4(a_p4),
    .halt(halt),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .br_valid(br_valid), .br_target(br_target),
    .pred_valid(pred_valid), .pred_target(pred_target),
    .misalign_err(a_mis)
  );

  pc_fetch_gen #(.WIDTH(32), .RST_VEC(32'h8000_0000), .C_EXT(1'b1), .EPOCH_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(req_ready),
    .req_pc(b_pc), .req_epoch(b_ep), .pc_plus4(b_p4),
    .halt(halt),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .br_valid(br_valid), .br_target(br_target),
    .pred_valid(pred_valid), .pred_target(pred_target),
    .misalign_err(b_mis)
  );

  // Monitor: every entry tagged for this cycle is checked on the negedge.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      logic        v, m;
      logic [31:0] pc, p4;
      logic [1:0]  ep;
      e = sbq.pop_front();
      v  = e.sel ? b_valid : a_valid;
      m  = e.sel ? b_mis   : a_mis;
      pc = e.sel ? b_pc    : a_pc;
      p4 = e.sel ? b_p4    : a_p4;
      ep = e.sel ? b_ep    : a_ep;
      checks++;
      if (e.cyc != cyc || v !== e.v || pc !== e.pc || ep !== e.ep ||
          m !== e.m || p4 !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL cyc%0d dut_%s: got v=%b pc=%h p4=%h ep=%0d m=%b, want v=%b pc=%h p4=%h ep=%0d m=%b",
                 e.cyc, e.sel ? "b" : "a", v, pc, p4, ep, m,
                 e.v, e.pc, e.pc + 32'd4, e.ep, e.m);
      end
    end
  end

  task automatic exp_b(input logic v, input logic [31:0] pc,
                       input logic [1:0] ep, input logic m);
    exp_t e;
    e.cyc = cyc + 1; e.sel = 1'b1;
    e.v = v; e.pc = pc; e.ep = ep; e.m = m;
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs and queue dut_a's outputs after that edge.
  task automatic step(input logic r, rdy, h, tv, bv, pv,
                      input logic [31:0] tvec, btgt, ptgt,
                      input logic v, input logic [31:0] pc,
                      input logic [1:0] ep, input logic m);
    exp_t e;
    rst = r; req_ready = rdy; halt = h;
    trap_valid = tv; br_valid = bv; pred_valid = pv;
    trap_vec = tvec; br_target = btgt; pred_target = ptgt;
    e.cyc = cyc + 1; e.sel = 1'b0;
    e.v = v; e.pc = pc; e.ep = ep; e.m = m;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; halt = 1'b0;
    trap_valid = 1'b0; br_valid = 1'b0; pred_valid = 1'b0;
    trap_vec = '0; br_target = '0; pred_target = '0;
    @(posedge clk);
    #1;
    //       r  rdy h  tv bv pv  tvec          btgt          ptgt          v  pc            ep m
    exp_b(1'b0, 32'h8000_0000, 2'd0, 1'b0);
    step(1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0000_0000, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0000, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0004, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0008, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_000C, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0010, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0010, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0010, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0010, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0014, 0, 0);
    // all three redirects at once; the losing pred target is misaligned
    step(0, 1, 0, 1, 1, 1, 32'h100,      32'h200,      32'h302,      1, 32'h0000_0100, 1, 0);
    exp_b(1'b1, 32'h0000_0206, 2'd2, 1'b0);
    step(0, 0, 0, 0, 1, 0, 32'h0,        32'h206,      32'h0,        1, 32'h0000_0204, 2, 1);
    exp_b(1'b1, 32'h0000_0206, 2'd2, 1'b0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0204, 2, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h20,       1, 32'h0000_0020, 3, 0);
    // halt with the request pending, then accepted
    step(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0020, 3, 0);
    step(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0020, 3, 0);
    step(0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0000_0024, 3, 0);
    step(0, 1, 1, 0, 1, 0, 32'h0,        32'h300,      32'h0,        0, 32'h0000_0300, 0, 0);
    step(0, 1, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0000_0300, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0300, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0304, 0, 0);
    // top-of-space wrap, trap bits [1:0] never flag misalignment
    step(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0,       32'h0,        1, 32'hFFFF_FFFC, 1, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0000, 1, 0);
    exp_b(1'b1, 32'h0000_0042, 2'd2, 1'b0);
    step(0, 1, 0, 0, 0, 1, 32'h0,        32'h0,        32'h43,       1, 32'h0000_0040, 2, 1);
    step(0, 1, 0, 0, 1, 1, 32'h0,        32'h80,       32'h90,       1, 32'h0000_0080, 3, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0080, 3, 0);
    // reset mid-stall beats a concurrent redirect
    exp_b(1'b0, 32'h8000_0000, 2'd0, 1'b0);
    step(1, 0, 0, 0, 1, 0, 32'h0,        32'h444,      32'h0,        0, 32'h0000_0000, 0, 0);
    step(0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0000_0000, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0000, 0, 0);
    step(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h0000_0004, 0, 0);
    repeat (3) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      begin
        repeat (2000) @(posedge clk);
      end
    join_any
    disable fork;
    if (!done) begin
      errors++;
      $display("FAIL timeout: got done=0, want done=1");
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
